ship_proj_ctrl: RTL and testbench
=================================

// Module: ship_proj_ctrl
// PURPOSE
//   Frame-rate sequencer for the player ship and its single projectile.
//   - Converts debounced d_left/d_right/d_fire into ship and projectile coordinates.
//   - Movement advances once per internal frame tick.
//   - Drives the coordinate outputs consumed by the renderer and the collision logic.
//   - Owns the projectile lifecycle: launch, flight, retire on hit or top of screen.
// PARAMETERS
//   COORD_W   10      width of every coordinate output
//   SCREEN_W  640     playfield width in pixels
//   SHIP_W    32      ship sprite width; ship_xcoord is the ship's left edge
//   SHIP_Y    440     fixed ship y; ship_ycoord is constant
//   SHIP_STEP 4       ship pixels moved per tick
//   PROJ_STEP 8       projectile pixels moved upward per tick
//   TICK_DIV  833333  clk cycles per frame tick (60 Hz at 50 MHz)
// PORTS
//   clk          in   1        system clock; all logic is on the rising edge
//   rst          in   1        synchronous reset, active-high
//   d_left       in   1        debounced left button (level)
//   d_right      in   1        debounced right button (level)
//   d_fire       in   1        debounced fire button (level)
//   d_reset      in   1        debounced game-reset button; same effect as rst
//   hit          in   1        collision logic reports the projectile struck a target
//   tick         out  1        one-cycle frame strobe
//   ship_xcoord  out  COORD_W  ship left edge x
//   ship_ycoord  out  COORD_W  ship y; always SHIP_Y
//   proj_xcoord  out  COORD_W  projectile x; 0 when idle
//   proj_ycoord  out  COORD_W  projectile y; 0 when idle
//   proj_active  out  1        1 while a projectile is in flight
// BEHAVIOUR
//   Reset
//   - rst or d_reset high at a clock edge gives, next cycle:
//     tick_cnt=0, tick=0, ship_xcoord=(SCREEN_W-SHIP_W)/2 (=304), ship_ycoord=SHIP_Y,
//     proj_xcoord=0, proj_ycoord=0, proj_active=0, state=IDLE, fire_pend=0, fire_q=0.
//   - Reset mid-flight discards the projectile immediately.
//   Tick generation
//   - tick_cnt counts 0..TICK_DIV-1 and wraps to 0.
//   - tick=1 for exactly the cycle in which tick_cnt==TICK_DIV-1.
//   - The first tick occurs TICK_DIV cycles after reset is released.
//   Fire capture
//   - fire_q is d_fire registered; a rising edge is d_fire & ~fire_q.
//   - A rising edge sets fire_pend. Holding d_fire never re-fires.
//   - fire_pend clears on every tick, whether or not it was used.
//   - An edge in the same cycle as tick counts for that tick.
//   Ship movement (tick cycles only)
//   - d_left xor d_right selects the direction; both pressed or neither means no move.
//   - Left: x = (x >= SHIP_STEP) ? x-SHIP_STEP : 0.
//   - Right: x = (x+SHIP_STEP <= SCREEN_W-SHIP_W) ? x+SHIP_STEP : SCREEN_W-SHIP_W.
//   - x never leaves [0, SCREEN_W-SHIP_W]. Compute in COORD_W+1 bits; no wrap.
//   Projectile FSM (IDLE, FLY)
//   - IDLE -> FLY on tick with fire_pend (or a same-cycle edge).
//     - proj_xcoord = pre-move ship_xcoord + SHIP_W/2.
//     - proj_ycoord = SHIP_Y - PROJ_STEP.
//     - proj_active = 1.
//   - FLY, hit=1 (any cycle, priority over tick): -> IDLE next cycle, coords 0, active 0.
//     A launch needs a later tick.
//   - FLY, tick, no hit:
//     - proj_ycoord < PROJ_STEP: -> IDLE (off top), coords 0.
//     - otherwise proj_ycoord -= PROJ_STEP; proj_xcoord holds.
//   - hit while IDLE is ignored.
//   - Fire edges during FLY are dropped; only one projectile exists at a time.
//   - All outputs are registered; a tick-cycle update is visible the following cycle.
// TESTING  (TICK_DIV=4 for simulation)
//   1. Reset release -> ship_x=304, ship_y=440, proj_active=0, tick every 4th cycle.
//   2. d_left held 80 ticks from 304 -> x drops 4/tick, saturates at 0, stays 0.
//      Right to 608 likewise.
//   3. d_left and d_right both held over 5 ticks -> ship_x unchanged.
//   4. Fire pulse with ship_x=100 -> next tick: proj_x=116, proj_y=432, active=1.
//      Then y 424, 416, ...; after y=0, next tick -> active=0, coords 0.
//   5. Fire while flying, and d_fire held across retire -> no second launch until
//      d_fire is released and pressed again.
//   6. hit asserted same cycle as tick while FLY -> IDLE, active=0;
//      d_reset pulse mid-flight -> all outputs return to reset values.

Source files
------------

// File: rtl/ship_proj_ctrl_if.sv
// Player-control / renderer bundle for ship_proj_ctrl.
//   master : button and collision inputs driver (board glue or bench)
//   slave  : ship_proj_ctrl itself
// Signals:
//   d_left, d_right, d_fire, d_reset  debounced buttons (level)
//   hit                               projectile struck a target
//   tick                              one-cycle frame strobe
//   ship_xcoord, ship_ycoord          ship left edge x, fixed ship y
//   proj_xcoord, proj_ycoord          projectile position (0 when idle)
//   proj_active                       projectile in flight
interface ship_proj_ctrl_if #(
  parameter int COORD_W = 10
);
  logic               d_left;
  logic               d_right;
  logic               d_fire;
  logic               d_reset;
  logic               hit;
  logic               tick;
  logic [COORD_W-1:0] ship_xcoord;
  logic [COORD_W-1:0] ship_ycoord;
  logic [COORD_W-1:0] proj_xcoord;
  logic [COORD_W-1:0] proj_ycoord;
  logic               proj_active;

  modport master (
    output d_left, d_right, d_fire, d_reset, hit,
    input  tick, ship_xcoord, ship_ycoord, proj_xcoord, proj_ycoord, proj_active
  );

  modport slave (
    input  d_left, d_right, d_fire, d_reset, hit,
    output tick, ship_xcoord, ship_ycoord, proj_xcoord, proj_ycoord, proj_active
  );
endinterface

// File: rtl/ship_proj_ctrl.sv
// Frame-rate sequencer for the player ship and its single projectile.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset (d_reset on the bus has the same effect)
//   bus  ship_proj_ctrl_if.slave: buttons/hit in, tick and coordinates out
// The ship moves once per frame tick; the projectile launches from the
// ship's centre on a tick after a fire press and climbs until hit or off-top.
module ship_proj_ctrl #(
  parameter int COORD_W   = 10,
  parameter int SCREEN_W  = 640,
  parameter int SHIP_W    = 32,
  parameter int SHIP_Y    = 440,
  parameter int SHIP_STEP = 4,
  parameter int PROJ_STEP = 8,
  parameter int TICK_DIV  = 833333
) (
  input  logic             clk,
  input  logic             rst,
  ship_proj_ctrl_if.slave  bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [COORD_W:0]   X_MAX_W  = (COORD_W+1)'(SCREEN_W - SHIP_W);
  localparam logic [COORD_W:0]   XSTEP_W  = (COORD_W+1)'(SHIP_STEP);
  localparam logic [COORD_W-1:0] X_RESET  = COORD_W'((SCREEN_W - SHIP_W) / 2);
  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(SCREEN_W - SHIP_W);
  localparam logic [COORD_W-1:0] X_STEP   = COORD_W'(SHIP_STEP);
  localparam logic [COORD_W-1:0] HALF_W   = COORD_W'(SHIP_W / 2);
  localparam logic [COORD_W-1:0] Y_SHIP   = COORD_W'(SHIP_Y);
  localparam logic [COORD_W-1:0] Y_LAUNCH = COORD_W'(SHIP_Y - PROJ_STEP);
  localparam logic [COORD_W-1:0] Y_STEP   = COORD_W'(PROJ_STEP);

  typedef enum logic {IDLE, FLY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic               fire_q;
  logic               fire_pend_q, fire_pend_d;
  logic [COORD_W-1:0] ship_x_q, ship_x_d;
  logic [COORD_W-1:0] proj_x_q, proj_x_d;
  logic [COORD_W-1:0] proj_y_q, proj_y_d;
  logic               active_q, active_d;

  logic               game_rst;
  logic               fire_edge;
  logic               fire_any;
  logic [COORD_W:0]   x_wide;
  logic [COORD_W:0]   x_sum;

  assign game_rst = rst | bus.d_reset;

  // tick is registered from the next counter value, so it is high exactly
  // while cnt_q sits at TICK_DIV-1.
  always_comb begin
    cnt_d  = tick_q ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_d == CNT_LAST);
  end

  always_comb begin
    fire_edge   = bus.d_fire & ~fire_q;
    fire_any    = fire_pend_q | fire_edge;
    fire_pend_d = tick_q ? 1'b0 : fire_any;

    x_wide   = {1'b0, ship_x_q};
    x_sum    = x_wide + XSTEP_W;
    ship_x_d = ship_x_q;
    if (tick_q) begin
      if (bus.d_left && !bus.d_right) begin
        ship_x_d = (x_wide >= XSTEP_W) ? ship_x_q - X_STEP : '0;
      end else if (bus.d_right && !bus.d_left) begin
        ship_x_d = (x_sum <= X_MAX_W) ? x_sum[COORD_W-1:0] : X_MAX;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    proj_x_d = proj_x_q;
    proj_y_d = proj_y_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (tick_q && fire_any) begin
          state_d  = FLY;
          proj_x_d = ship_x_q + HALF_W;
          proj_y_d = Y_LAUNCH;
          active_d = 1'b1;
        end
      end
      FLY: begin
        if (bus.hit) begin
          state_d  = IDLE;
          proj_x_d = '0;
          proj_y_d = '0;
          active_d = 1'b0;
        end else if (tick_q) begin
          if (proj_y_q < Y_STEP) begin
            state_d  = IDLE;
            proj_x_d = '0;
            proj_y_d = '0;
            active_d = 1'b0;
          end else begin
            proj_y_d = proj_y_q - Y_STEP;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        proj_x_d = '0;
        proj_y_d = '0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (game_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      fire_q      <= 1'b0;
      fire_pend_q <= 1'b0;
      ship_x_q    <= X_RESET;
      proj_x_q    <= '0;
      proj_y_q    <= '0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      fire_q      <= bus.d_fire;
      fire_pend_q <= fire_pend_d;
      ship_x_q    <= ship_x_d;
      proj_x_q    <= proj_x_d;
      proj_y_q    <= proj_y_d;
      active_q    <= active_d;
    end
  end

  assign bus.tick        = tick_q;
  assign bus.ship_xcoord = ship_x_q;
  assign bus.ship_ycoord = Y_SHIP;
  assign bus.proj_xcoord = proj_x_q;
  assign bus.proj_ycoord = proj_y_q;
  assign bus.proj_active = active_q;

endmodule

// File: tb/tb_ship_proj_ctrl.sv
// Directed bench for ship_proj_ctrl with a 4-cycle frame tick.
module tb_ship_proj_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  ship_proj_ctrl_if #(.COORD_W(10)) bus ();

  ship_proj_ctrl #(
    .COORD_W  (10),
    .SCREEN_W (640),
    .SHIP_W   (32),
    .SHIP_Y   (440),
    .SHIP_STEP(4),
    .PROJ_STEP(8),
    .TICK_DIV (4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the negedge following the next tick, i.e. where the
  // tick-cycle update is visible.
  task automatic do_tick();
    int n;
    n = 0;
    while (bus.tick !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.tick !== 1'b1) $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", bus.tick, n);
    else passes++;
    @(negedge clk);
  endtask

  task automatic wait_tick_high();
    int n;
    n = 0;
    while (bus.tick !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.tick !== 1'b1) $display("FAIL tick_wait: tick=%b after %0d cycles, required 1", bus.tick, n);
    else passes++;
  endtask

  task automatic pulse_fire();
    bus.d_fire = 1'b1;
    @(negedge clk);
    bus.d_fire = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.ship_xcoord !== 10'd304) $display("FAIL reset_ship_x: got %0d, required 304", bus.ship_xcoord);
    else passes++;
    checks++;
    if (bus.ship_ycoord !== 10'd440) $display("FAIL reset_ship_y: got %0d, required 440", bus.ship_ycoord);
    else passes++;
    checks++;
    if (bus.proj_active !== 1'b0 || bus.proj_xcoord !== 10'd0 || bus.proj_ycoord !== 10'd0)
      $display("FAIL reset_proj: got active=%b x=%0d y=%0d, required 0/0/0",
               bus.proj_active, bus.proj_xcoord, bus.proj_ycoord);
    else passes++;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (bus.tick !== ((i % 4) == 3)) $display("FAIL tick_period: cycle %0d tick=%b, required %b", i, bus.tick, ((i % 4) == 3));
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_move_saturate();
    int x_exp;
    x_exp = 304;
    bus.d_left = 1'b1;
    for (int i = 0; i < 80; i++) begin
      do_tick();
      x_exp = (x_exp >= 4) ? x_exp - 4 : 0;
      checks++;
      if (bus.ship_xcoord !== 10'(x_exp)) $display("FAIL move_left: tick %0d x=%0d, required %0d", i, bus.ship_xcoord, x_exp);
      else passes++;
    end
    bus.d_left  = 1'b0;
    bus.d_right = 1'b1;
    for (int i = 0; i < 160; i++) begin
      do_tick();
      x_exp = (x_exp + 4 <= 608) ? x_exp + 4 : 608;
      checks++;
      if (bus.ship_xcoord !== 10'(x_exp)) $display("FAIL move_right: tick %0d x=%0d, required %0d", i, bus.ship_xcoord, x_exp);
      else passes++;
    end
    bus.d_right = 1'b0;
  endtask

  task automatic test_both_pressed();
    bus.d_left  = 1'b1;
    bus.d_right = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_tick();
      checks++;
      if (bus.ship_xcoord !== 10'd608) $display("FAIL both_pressed: tick %0d x=%0d, required 608", i, bus.ship_xcoord);
      else passes++;
    end
    bus.d_right = 1'b0;
    bus.d_left  = 1'b0;
    // return to 304 via game reset, then walk left to x=100
    bus.d_reset = 1'b1;
    @(negedge clk);
    bus.d_reset = 1'b0;
    bus.d_left  = 1'b1;
    for (int i = 0; i < 51; i++) do_tick();
    bus.d_left = 1'b0;
    checks++;
    if (bus.ship_xcoord !== 10'd100) $display("FAIL walk_to_100: x=%0d, required 100", bus.ship_xcoord);
    else passes++;
  endtask

  task automatic test_fire_flight();
    int y_exp;
    pulse_fire();
    checks++;
    if (bus.proj_active !== 1'b0) $display("FAIL fire_before_tick: active=%b, required 0", bus.proj_active);
    else passes++;
    do_tick();
    checks++;
    if (bus.proj_active !== 1'b1 || bus.proj_xcoord !== 10'd116 || bus.proj_ycoord !== 10'd432)
      $display("FAIL launch: got active=%b x=%0d y=%0d, required 1/116/432",
               bus.proj_active, bus.proj_xcoord, bus.proj_ycoord);
    else passes++;
    y_exp = 432;
    while (y_exp > 0) begin
      do_tick();
      y_exp = y_exp - 8;
      checks++;
      if (bus.proj_active !== 1'b1 || bus.proj_xcoord !== 10'd116 || bus.proj_ycoord !== 10'(y_exp))
        $display("FAIL flight: got active=%b x=%0d y=%0d, required 1/116/%0d",
                 bus.proj_active, bus.proj_xcoord, bus.proj_ycoord, y_exp);
      else passes++;
    end
    do_tick();
    checks++;
    if (bus.proj_active !== 1'b0 || bus.proj_xcoord !== 10'd0 || bus.proj_ycoord !== 10'd0)
      $display("FAIL retire_top: got active=%b x=%0d y=%0d, required 0/0/0",
               bus.proj_active, bus.proj_xcoord, bus.proj_ycoord);
    else passes++;
    checks++;
    if (bus.ship_xcoord !== 10'd100) $display("FAIL ship_hold: x=%0d, required 100", bus.ship_xcoord);
    else passes++;
  endtask

  task automatic test_fire_hold();
    int n;
    pulse_fire();
    do_tick();
    do_tick();
    // second press while flying must not restart the projectile
    pulse_fire();
    do_tick();
    checks++;
    if (bus.proj_active !== 1'b1 || bus.proj_ycoord !== 10'd416)
      $display("FAIL fire_in_flight: got active=%b y=%0d, required 1/416", bus.proj_active, bus.proj_ycoord);
    else passes++;
    bus.d_fire = 1'b1;
    n = 0;
    while (bus.proj_active === 1'b1 && n < 60) begin
      do_tick();
      n++;
    end
    checks++;
    if (bus.proj_active !== 1'b0) $display("FAIL retire_hold: active=%b after %0d ticks, required 0", bus.proj_active, n);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      do_tick();
      checks++;
      if (bus.proj_active !== 1'b0) $display("FAIL held_no_refire: tick %0d active=%b, required 0", i, bus.proj_active);
      else passes++;
    end
    bus.d_fire = 1'b0;
    @(negedge clk);
    pulse_fire();
    do_tick();
    checks++;
    if (bus.proj_active !== 1'b1 || bus.proj_xcoord !== 10'd116 || bus.proj_ycoord !== 10'd432)
      $display("FAIL refire: got active=%b x=%0d y=%0d, required 1/116/432",
               bus.proj_active, bus.proj_xcoord, bus.proj_ycoord);
    else passes++;
  endtask

  task automatic test_hit_and_reset();
    // projectile from test_fire_hold is in flight; hit on the tick cycle
    wait_tick_high();
    bus.hit = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0;
    checks++;
    if (bus.proj_active !== 1'b0 || bus.proj_xcoord !== 10'd0 || bus.proj_ycoord !== 10'd0)
      $display("FAIL hit_on_tick: got active=%b x=%0d y=%0d, required 0/0/0",
               bus.proj_active, bus.proj_xcoord, bus.proj_ycoord);
    else passes++;
    // hit while idle is ignored
    bus.hit = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0;
    do_tick();
    checks++;
    if (bus.proj_active !== 1'b0) $display("FAIL hit_idle: active=%b, required 0", bus.proj_active);
    else passes++;
    // fire edge in the same cycle as tick launches on that tick
    wait_tick_high();
    bus.d_fire = 1'b1;
    @(negedge clk);
    bus.d_fire = 1'b0;
    checks++;
    if (bus.proj_active !== 1'b1 || bus.proj_xcoord !== 10'd116 || bus.proj_ycoord !== 10'd432)
      $display("FAIL same_cycle_fire: got active=%b x=%0d y=%0d, required 1/116/432",
               bus.proj_active, bus.proj_xcoord, bus.proj_ycoord);
    else passes++;
    // hit between ticks
    bus.hit = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0;
    checks++;
    if (bus.proj_active !== 1'b0 || bus.proj_ycoord !== 10'd0)
      $display("FAIL hit_mid_frame: got active=%b y=%0d, required 0/0", bus.proj_active, bus.proj_ycoord);
    else passes++;
    // relaunch, move the ship, then d_reset mid-flight
    pulse_fire();
    bus.d_right = 1'b1;
    do_tick();
    do_tick();
    bus.d_right = 1'b0;
    checks++;
    if (bus.proj_active !== 1'b1 || bus.ship_xcoord !== 10'd108)
      $display("FAIL pre_reset: got active=%b ship_x=%0d, required 1/108", bus.proj_active, bus.ship_xcoord);
    else passes++;
    @(negedge clk);
    bus.d_reset = 1'b1;
    @(negedge clk);
    bus.d_reset = 1'b0;
    checks++;
    if (bus.ship_xcoord !== 10'd304 || bus.ship_ycoord !== 10'd440 || bus.proj_active !== 1'b0 ||
        bus.proj_xcoord !== 10'd0 || bus.proj_ycoord !== 10'd0 || bus.tick !== 1'b0)
      $display("FAIL d_reset: got ship=%0d,%0d proj=%0d,%0d active=%b tick=%b, required 304,440 0,0 0 0",
               bus.ship_xcoord, bus.ship_ycoord, bus.proj_xcoord, bus.proj_ycoord, bus.proj_active, bus.tick);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.tick !== (i == 3)) $display("FAIL tick_after_d_reset: cycle %0d tick=%b, required %b", i, bus.tick, (i == 3));
      else passes++;
      @(negedge clk);
    end
  endtask

  initial begin
    checks      = 0;
    passes      = 0;
    rst         = 1'b1;
    bus.d_left  = 1'b0;
    bus.d_right = 1'b0;
    bus.d_fire  = 1'b0;
    bus.d_reset = 1'b0;
    bus.hit     = 1'b0;
    @(negedge clk);
    test_reset();
    test_move_saturate();
    test_both_pressed();
    test_fire_flight();
    test_fire_hold();
    test_hit_and_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
